// File: rtl/load_wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : load_wb_queue_if
// Description : Issue, response, hazard-query and register-file write bundle
//               for the load write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_wb_queue_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(XLEN/8)
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              issue_valid;
  logic              issue_ready;
  logic [REG_AW-1:0] issue_rd;
  logic [OFF_W-1:0]  issue_off;
  logic [2:0]        issue_funct3;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic              flush;
  logic [REG_AW-1:0] chk_rs;
  logic              chk_hit;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
  logic [CNT_W-1:0]  count;
  logic              rsp_err;
  logic              fmt_err;

  // Issue/memory side drives requests and observes the unit's results
  modport master (
    output issue_valid, issue_rd, issue_off, issue_funct3,
    output rsp_valid, rsp_data, flush, chk_rs,
    input  issue_ready, chk_hit, reg_we, reg_waddr, reg_wdata,
    input  count, rsp_err, fmt_err
  );

  // The write-back queue itself
  modport slave (
    input  issue_valid, issue_rd, issue_off, issue_funct3,
    input  rsp_valid, rsp_data, flush, chk_rs,
    output issue_ready, chk_hit, reg_we, reg_waddr, reg_wdata,
    output count, rsp_err, fmt_err
  );
endinterface
`default_nettype wire

// File: rtl/load_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : load_wb_queue
// Description : Multi-entry load write-back queue. Tracks up to DEPTH
//               outstanding loads, aligns/extends in-order responses and
//               issues one registered register-file write per response.
//               Supports flush-kill of in-flight loads and load-use query.
// Revision    : 1.0 - initial release
// ============================================================================
module load_wb_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst,
  load_wb_queue_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  // Queue storage: live bit is kept in a vector so flush can clear it at once
  logic [DEPTH-1:0]  r_live;
  logic [REG_AW-1:0] r_rd  [DEPTH];
  logic [OFF_W-1:0]  r_off [DEPTH];
  logic [2:0]        r_f3  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_h_live;
  logic [REG_AW-1:0] w_h_rd;
  logic [OFF_W-1:0]  w_h_off;
  logic [2:0]        w_h_f3;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [XLEN-1:0]   w_ext;
  logic              w_legal;
  logic              w_wr;
  logic              w_hit;

  assign bus.issue_ready = (r_count < c_depth);
  assign bus.count       = r_count;

  // Pop uses the occupancy at cycle start, so a same-cycle push is never matched
  assign w_push = bus.issue_valid && bus.issue_ready;
  assign w_pop  = bus.rsp_valid && (r_count != '0);

  assign w_h_live = r_live[r_rd_ptr];
  assign w_h_rd   = r_rd[r_rd_ptr];
  assign w_h_off  = r_off[r_rd_ptr];
  assign w_h_f3   = r_f3[r_rd_ptr];

  // Lane selection: shift the selected lane down to bit 0, then truncate
  assign w_byte = 8'(bus.rsp_data >> {w_h_off, 3'b000});
  assign w_half = 16'(bus.rsp_data >> {w_h_off[OFF_W-1:1], 4'b0000});

  generate
    if (XLEN == 64) begin : g_word_lane
      assign w_word = 32'(bus.rsp_data >> {w_h_off[OFF_W-1:2], 5'b00000});
    end else begin : g_word_full
      assign w_word = 32'(bus.rsp_data);
    end
  endgenerate

  // Decode funct3 into the extended write data and a legality flag
  always_comb begin
    w_ext   = '0;
    w_legal = 1'b1;
    case (w_h_f3)
      3'b000: w_ext = XLEN'($signed(w_byte));
      3'b001: w_ext = XLEN'($signed(w_half));
      3'b010: w_ext = XLEN'($signed(w_word));
      3'b011: begin
        if (XLEN == 64) w_ext = bus.rsp_data;
        else            w_legal = 1'b0;
      end
      3'b100: w_ext = XLEN'(w_byte);
      3'b101: w_ext = XLEN'(w_half);
      3'b110: begin
        if (XLEN == 64) w_ext = XLEN'(w_word);
        else            w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // A write happens only for a live head with a non-zero, legal destination
  assign w_wr = w_pop && w_h_live && (w_h_rd != '0) && w_legal;

  // Pointer, occupancy and live-bit bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
    end else begin
      // Flush/pop clear first; a same-cycle push then sets its own live bit
      if (bus.flush)  r_live <= '0;
      else if (w_pop) r_live[r_rd_ptr] <= 1'b0;
      if (w_push)     r_live[r_wr_ptr] <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload capture; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wr_ptr]  <= bus.issue_rd;
      r_off[r_wr_ptr] <= bus.issue_off;
      r_f3[r_wr_ptr]  <= bus.issue_funct3;
    end
  end

  // Registered register-file write and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.reg_we    <= 1'b0;
      bus.reg_waddr <= '0;
      bus.reg_wdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.fmt_err   <= 1'b0;
    end else begin
      bus.reg_we    <= w_wr;
      bus.reg_waddr <= w_wr ? w_h_rd : '0;
      bus.reg_wdata <= w_wr ? w_ext  : '0;
      bus.rsp_err   <= bus.rsp_valid && (r_count == '0);
      bus.fmt_err   <= w_pop && !w_legal;
    end
  end

  // Load-use hazard: any live entry targeting the queried register
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_rd[i] == bus.chk_rs)) w_hit = 1'b1;
    end
  end

  assign bus.chk_hit = (bus.chk_rs != '0) && w_hit;

endmodule
`default_nettype wire
